// File: rtl/note_key_player.sv
// rtl/note_key_player.sv - queued note/instrument events replayed as timed two-digit keycodes
//
// Purpose: playback source for the synth. Events are queued in a small FIFO. Each event is
// mapped to a keycode (tens digit on key_hi, ones digit on key_lo) and held on the bus for
// its duration. A released-key gap of 00 follows each note.
// Ports:
//   clk, rst_n                        clock, asynchronous active-low reset
//   ev_valid/ev_ready                 event handshake (ev_ready = FIFO not full)
//   ev_instr, ev_note, ev_octave,
//   ev_flat, ev_dur                   event payload
//   key_hi, key_lo                    registered keycode digits
//   busy                              FSM active or events queued
//   bad_event                         one-cycle pulse for an event with no key mapping
module note_key_player #(
    parameter int TICK_DIV  = 50000,
    parameter int GAP_TICKS = 2,
    parameter int DEPTH     = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ev_valid,
    output logic       ev_ready,
    input  logic       ev_instr,
    input  logic [2:0] ev_note,
    input  logic [2:0] ev_octave,
    input  logic       ev_flat,
    input  logic [7:0] ev_dur,
    output logic [3:0] key_hi,
    output logic [3:0] key_lo,
    output logic       busy,
    output logic       bad_event
);
    localparam int AW = $clog2(DEPTH);
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PRESS = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    // FIFO entry layout: {instr, note[2:0], octave[2:0], flat, dur[7:0]}
    logic [15:0]   mem_q [DEPTH];
    logic [AW:0]   wr_ptr_q, rd_ptr_q;
    logic          fifo_full, fifo_empty, push, pop;
    logic [15:0]   head;

    logic [1:0]    state_q, state_d;
    logic [7:0]    key_q, key_d;
    logic          bad_q, bad_d;
    logic [TW-1:0] tick_q, tick_d;
    logic [7:0]    rem_q, rem_d;
    logic          tick_wrap, last_tick;
    logic [8:0]    code;

    // Extra pointer bit distinguishes full from empty.
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign push       = ev_valid && !fifo_full;
    assign pop        = (state_q == ST_IDLE) && !fifo_empty;
    assign head       = mem_q[rd_ptr_q[AW-1:0]];

    // Returns {valid, tens, ones}; keycodes are written as BCD so 8'h29 means key 2/9.
    function automatic logic [8:0] map_event(input logic instr, input logic [2:0] note,
                                             input logic [2:0] oct, input logic flat);
        logic [8:0] r;
        r = 9'h000;
        if (instr) begin
            r = {1'b1, 4'd5, (note[0] ? 4'd9 : 4'd8)};
        end else begin
            case ({oct, note, flat})
                {3'd1, 3'd1, 1'b0}: r = {1'b1, 8'h29};
                {3'd1, 3'd2, 1'b1}: r = {1'b1, 8'h22};
                {3'd1, 3'd2, 1'b0}: r = {1'b1, 8'h27};
                {3'd1, 3'd3, 1'b1}: r = {1'b1, 8'h07};
                {3'd1, 3'd3, 1'b0}: r = {1'b1, 8'h06};
                {3'd1, 3'd4, 1'b0}: r = {1'b1, 8'h25};
                {3'd1, 3'd5, 1'b1}: r = {1'b1, 8'h10};
                {3'd1, 3'd5, 1'b0}: r = {1'b1, 8'h05};
                {3'd1, 3'd6, 1'b1}: r = {1'b1, 8'h11};
                {3'd1, 3'd6, 1'b0}: r = {1'b1, 8'h17};
                {3'd1, 3'd7, 1'b1}: r = {1'b1, 8'h13};
                {3'd1, 3'd7, 1'b0}: r = {1'b1, 8'h16};
                {3'd2, 3'd1, 1'b0}: r = {1'b1, 8'h54};
                {3'd2, 3'd2, 1'b1}: r = {1'b1, 8'h15};
                {3'd2, 3'd2, 1'b0}: r = {1'b1, 8'h55};
                {3'd2, 3'd3, 1'b1}: r = {1'b1, 8'h51};
                {3'd2, 3'd3, 1'b0}: r = {1'b1, 8'h56};
                {3'd2, 3'd4, 1'b0}: r = {1'b1, 8'h20};
                {3'd2, 3'd5, 1'b1}: r = {1'b1, 8'h31};
                {3'd2, 3'd5, 1'b0}: r = {1'b1, 8'h26};
                {3'd2, 3'd6, 1'b1}: r = {1'b1, 8'h32};
                {3'd2, 3'd6, 1'b0}: r = {1'b1, 8'h08};
                {3'd2, 3'd7, 1'b1}: r = {1'b1, 8'h33};
                {3'd2, 3'd7, 1'b0}: r = {1'b1, 8'h21};
                {3'd3, 3'd1, 1'b0}: r = {1'b1, 8'h23};
                {3'd3, 3'd2, 1'b1}: r = {1'b1, 8'h35};
                {3'd3, 3'd2, 1'b0}: r = {1'b1, 8'h28};
                {3'd3, 3'd3, 1'b1}: r = {1'b1, 8'h36};
                {3'd3, 3'd3, 1'b0}: r = {1'b1, 8'h24};
                {3'd3, 3'd4, 1'b0}: r = {1'b1, 8'h12};
                {3'd3, 3'd5, 1'b1}: r = {1'b1, 8'h38};
                {3'd3, 3'd5, 1'b0}: r = {1'b1, 8'h18};
                {3'd3, 3'd6, 1'b1}: r = {1'b1, 8'h39};
                {3'd3, 3'd6, 1'b0}: r = {1'b1, 8'h19};
                {3'd3, 3'd7, 1'b1}: r = {1'b1, 8'h45};
                {3'd3, 3'd7, 1'b0}: r = {1'b1, 8'h47};
                {3'd4, 3'd1, 1'b0}: r = {1'b1, 8'h48};
                default:            r = 9'h000;
            endcase
        end
        return r;
    endfunction

    assign code = map_event(head[15], head[14:12], head[11:9], head[8]);

    assign tick_wrap = (tick_q == TW'(TICK_DIV - 1));
    assign last_tick = tick_wrap && (rem_q == 8'd1);

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        bad_d   = 1'b0;
        tick_d  = tick_q;
        rem_d   = rem_q;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    if (code[8]) begin
                        state_d = ST_PRESS;
                        key_d   = code[7:0];
                        tick_d  = '0;
                        // Instrument changes are a fixed one-tick tap; zero duration plays one tick.
                        if (head[15] || (head[7:0] == 8'd0)) rem_d = 8'd1;
                        else                                  rem_d = head[7:0];
                    end else begin
                        bad_d = 1'b1;
                    end
                end
            end
            ST_PRESS, ST_GAP: begin
                tick_d = tick_wrap ? '0 : tick_q + TW'(1);
                if (tick_wrap) rem_d = rem_q - 8'd1;
                if (last_tick) begin
                    key_d  = 8'h00;
                    tick_d = '0;
                    if ((state_q == ST_PRESS) && (GAP_TICKS != 0)) begin
                        state_d = ST_GAP;
                        rem_d   = 8'(GAP_TICKS);
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= {ev_instr, ev_note, ev_octave, ev_flat, ev_dur};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            key_q    <= 8'h00;
            bad_q    <= 1'b0;
            tick_q   <= '0;
            rem_q    <= 8'd0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            bad_q   <= bad_d;
            tick_q  <= tick_d;
            rem_q   <= rem_d;
            if (push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
        end
    end

    assign ev_ready  = !fifo_full;
    assign key_hi    = key_q[7:4];
    assign key_lo    = key_q[3:0];
    assign bad_event = bad_q;
    assign busy      = (state_q != ST_IDLE) || !fifo_empty;
endmodule

// File: tb/tb_note_key_player.sv
// tb/tb_note_key_player.sv - directed bench for note_key_player
module tb_note_key_player;
    localparam int TD = 4;
    localparam int GT = 1;
    localparam int DP = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ev_valid = 1'b0;
    logic       ev_ready;
    logic       ev_instr = 1'b0;
    logic [2:0] ev_note = 3'd0;
    logic [2:0] ev_octave = 3'd0;
    logic       ev_flat = 1'b0;
    logic [7:0] ev_dur = 8'd0;
    logic [3:0] key_hi, key_lo;
    logic       busy, bad_event;
    logic [7:0] keyv;

    int checks = 0;
    int failures = 0;

    note_key_player #(.TICK_DIV(TD), .GAP_TICKS(GT), .DEPTH(DP)) dut (
        .clk(clk), .rst_n(rst_n), .ev_valid(ev_valid), .ev_ready(ev_ready),
        .ev_instr(ev_instr), .ev_note(ev_note), .ev_octave(ev_octave), .ev_flat(ev_flat),
        .ev_dur(ev_dur), .key_hi(key_hi), .key_lo(key_lo), .busy(busy), .bad_event(bad_event)
    );

    always #5 clk = ~clk;
    assign keyv = {key_hi, key_lo};

    // Key run-length log sampled just after each rising edge.
    int run_val[$];
    int run_len[$];
    int cur_val = -1;
    int cur_len = 0;
    int bad_cycles = 0;
    bit nz_seen = 1'b0;

    always begin
        @(posedge clk);
        #1;
        if (bad_event) bad_cycles++;
        if (keyv != 8'h00) nz_seen = 1'b1;
        if (int'(keyv) == cur_val) begin
            cur_len++;
        end else begin
            if (cur_val >= 0) begin
                run_val.push_back(cur_val);
                run_len.push_back(cur_len);
            end
            cur_val = int'(keyv);
            cur_len = 1;
        end
    end

    function automatic int first_nz();
        for (int i = 0; i < run_val.size(); i++) if (run_val[i] != 0) return i;
        return -1;
    endfunction

    task automatic clear_log();
        run_val.delete();
        run_len.delete();
        bad_cycles = 0;
        nz_seen = 1'b0;
    endtask

    task automatic push(input bit instr, input logic [2:0] note, input logic [2:0] oct,
                        input bit flat, input logic [7:0] dur);
        ev_instr = instr; ev_note = note; ev_octave = oct; ev_flat = flat; ev_dur = dur;
        ev_valid = 1'b1;
        for (int n = 0; n < 3000 && !ev_ready; n++) @(negedge clk);
        checks++;
        if (!ev_ready) begin
            failures++;
            $display("FAIL push_timeout ev_ready=%0b expected=1", ev_ready);
        end
        @(negedge clk);
        ev_valid = 1'b0;
    endtask

    task automatic wait_idle(input int limit);
        for (int n = 0; n < limit && busy; n++) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL wait_idle busy=%0b expected=0", busy);
        end
    endtask

    task automatic wait_key(input int limit);
        for (int n = 0; n < limit && keyv == 8'h00; n++) @(negedge clk);
        checks++;
        if (keyv == 8'h00) begin
            failures++;
            $display("FAIL wait_key key=%h expected=nonzero", keyv);
        end
    endtask

    task automatic test_reset();
        #12;
        checks++; if (keyv !== 8'h00) begin failures++; $display("FAIL reset_key key=%h expected=00", keyv); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy busy=%0b expected=0", busy); end
        checks++; if (bad_event !== 1'b0) begin failures++; $display("FAIL reset_bad bad=%0b expected=0", bad_event); end
        checks++; if (ev_ready !== 1'b1) begin failures++; $display("FAIL reset_ready ready=%0b expected=1", ev_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_note();
        clear_log();
        push(1'b0, 3'd1, 3'd1, 1'b0, 8'd3);
        checks++; if (keyv !== 8'h00) begin failures++; $display("FAIL single_latency key=%h expected=00", keyv); end
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            checks++;
            if (keyv !== 8'h29) begin failures++; $display("FAIL single_on[%0d] key=%h expected=29", i, keyv); end
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (keyv !== 8'h00 || busy !== 1'b1) begin
                failures++;
                $display("FAIL single_gap[%0d] key=%h busy=%0b expected=00/1", i, keyv, busy);
            end
        end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_done busy=%0b expected=0", busy); end
    endtask

    task automatic test_back_to_back();
        int ev[5];
        int el[5];
        int idx;
        ev = '{'h32, 0, 'h48, 0, 'h45};
        el = '{4, 5, 4, 5, 4};
        clear_log();
        push(1'b0, 3'd6, 3'd2, 1'b1, 8'd1);
        push(1'b0, 3'd1, 3'd4, 1'b0, 8'd1);
        push(1'b0, 3'd7, 3'd3, 1'b1, 8'd1);
        wait_idle(200);
        idx = first_nz();
        checks++;
        if (idx < 0 || run_val.size() < idx + 5) begin
            failures++;
            $display("FAIL b2b_runs found=%0d expected>=5", run_val.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (run_val[idx+i] != ev[i] || run_len[idx+i] != el[i]) begin
                    failures++;
                    $display("FAIL b2b_run[%0d] key=%h len=%0d expected=%h/%0d",
                             i, run_val[idx+i], run_len[idx+i], ev[i], el[i]);
                end
            end
        end
    endtask

    task automatic test_bad_events();
        clear_log();
        push(1'b0, 3'd4, 3'd1, 1'b1, 8'd1);
        push(1'b0, 3'd2, 3'd4, 1'b0, 8'd1);
        push(1'b0, 3'd0, 3'd2, 1'b0, 8'd1);
        for (int n = 0; n < 4 && busy; n++) @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL bad_idle busy=%0b expected=0", busy); end
        @(negedge clk);
        @(negedge clk);
        checks++; if (bad_cycles != 3) begin failures++; $display("FAIL bad_pulses count=%0d expected=3", bad_cycles); end
        checks++; if (nz_seen) begin failures++; $display("FAIL bad_key_moved seen=%0b expected=0", nz_seen); end
    endtask

    task automatic test_fifo_full();
        int ev[11];
        int el[11];
        int idx;
        ev = '{'h06, 0, 'h26, 0, 'h23, 0, 'h22, 0, 'h21, 0, 'h36};
        el = '{1020, 5, 4, 5, 4, 5, 4, 5, 8, 5, 4};
        clear_log();
        push(1'b0, 3'd3, 3'd1, 1'b0, 8'd255);
        wait_key(10);
        push(1'b0, 3'd5, 3'd2, 1'b0, 8'd0);
        push(1'b0, 3'd1, 3'd3, 1'b0, 8'd1);
        push(1'b0, 3'd2, 3'd1, 1'b1, 8'd1);
        checks++; if (ev_ready !== 1'b1) begin failures++; $display("FAIL full_early ready=%0b expected=1", ev_ready); end
        push(1'b0, 3'd7, 3'd2, 1'b0, 8'd2);
        checks++; if (ev_ready !== 1'b0) begin failures++; $display("FAIL full_ready ready=%0b expected=0", ev_ready); end
        push(1'b0, 3'd3, 3'd3, 1'b1, 8'd1);
        wait_idle(3000);
        idx = first_nz();
        checks++;
        if (idx < 0 || run_val.size() < idx + 11) begin
            failures++;
            $display("FAIL full_runs found=%0d expected>=11", run_val.size());
        end else begin
            for (int i = 0; i < 11; i++) begin
                checks++;
                if (run_val[idx+i] != ev[i] || run_len[idx+i] != el[i]) begin
                    failures++;
                    $display("FAIL full_run[%0d] key=%h len=%0d expected=%h/%0d",
                             i, run_val[idx+i], run_len[idx+i], ev[i], el[i]);
                end
            end
        end
    endtask

    task automatic test_instrument();
        int ev[3];
        int el[3];
        int idx;
        ev = '{'h59, 0, 'h58};
        el = '{4, 5, 4};
        clear_log();
        push(1'b1, 3'd1, 3'd0, 1'b0, 8'd50);
        push(1'b1, 3'd0, 3'd0, 1'b0, 8'd9);
        wait_idle(200);
        idx = first_nz();
        checks++;
        if (idx < 0 || run_val.size() < idx + 3) begin
            failures++;
            $display("FAIL instr_runs found=%0d expected>=3", run_val.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (run_val[idx+i] != ev[i] || run_len[idx+i] != el[i]) begin
                    failures++;
                    $display("FAIL instr_run[%0d] key=%h len=%0d expected=%h/%0d",
                             i, run_val[idx+i], run_len[idx+i], ev[i], el[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_note();
        clear_log();
        push(1'b0, 3'd2, 3'd2, 1'b0, 8'd20);
        wait_key(10);
        push(1'b0, 3'd4, 3'd2, 1'b0, 8'd1);
        push(1'b0, 3'd5, 3'd2, 1'b0, 8'd1);
        push(1'b0, 3'd6, 3'd2, 1'b0, 8'd1);
        checks++; if (keyv !== 8'h55) begin failures++; $display("FAIL rst_pre_key key=%h expected=55", keyv); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (keyv !== 8'h00) begin failures++; $display("FAIL rst_async_key key=%h expected=00", keyv); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_async_busy busy=%0b expected=0", busy); end
        checks++; if (ev_ready !== 1'b1) begin failures++; $display("FAIL rst_async_ready ready=%0b expected=1", ev_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        nz_seen = 1'b0;
        repeat (40) @(negedge clk);
        checks++; if (nz_seen) begin failures++; $display("FAIL rst_replay seen=%0b expected=0", nz_seen); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy busy=%0b expected=0", busy); end
        checks++; if (ev_ready !== 1'b1) begin failures++; $display("FAIL rst_ready ready=%0b expected=1", ev_ready); end
    endtask

    initial begin
        test_reset();
        test_single_note();
        test_back_to_back();
        test_bad_events();
        test_fifo_full();
        test_instrument();
        test_reset_mid_note();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
